// File: rtl/diff_line_rx_pkg.sv
// Shared types for the differential line receiver: line symbols, FSM states, error flags.
// Line symbol encoding is {rx_n, rx_p}, which gives SE0=0, J=1, K=2, SE1=3 directly.
package diff_line_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ABORT
  } rx_state_t;

  localparam int SYNC_LEN = 8;

  // Bit order matches the err port: [0]=stuff, [1]=SE1, [2]=partial word.
  typedef struct packed {
    logic partial;
    logic se1;
    logic stuff;
  } rx_err_t;

  function automatic line_sym_t decode_sym(input logic p, input logic n);
    return line_sym_t'({n, p});
  endfunction

  function automatic logic is_jk(input line_sym_t s);
    return (s == LS_J) || (s == LS_K);
  endfunction

endpackage

// File: rtl/diff_rx_nrzi_unstuff.sv
// NRZI decode and bit unstuffing; outputs are combinational on the sampled symbol (0 cycles).
// No backpressure: one symbol per sym_vld strobe, stuffed zeros come out with bit_vld low.
module diff_rx_nrzi_unstuff
  import diff_line_rx_pkg::*;
#(
  parameter int STUFF_LEN = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sym_vld,
  input  line_sym_t sym,
  input  logic      unstuff_en,
  output logic      bit_dat,
  output logic      bit_vld,
  output logic      stuff_err
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  line_sym_t         prev_jk;
  logic [ONES_W-1:0] ones_cnt;
  logic              jk;
  logic              stuff_pos;

  always_comb begin
    jk        = is_jk(sym);
    bit_dat   = (sym == prev_jk);
    stuff_pos = unstuff_en && (ones_cnt == ONES_W'(STUFF_LEN));
    bit_vld   = sym_vld && jk && !stuff_pos;
    stuff_err = sym_vld && jk && stuff_pos && bit_dat;
  end

  // The run of ones only counts inside the data phase; SYNC's trailing 1 is excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_jk  <= LS_J;
      ones_cnt <= '0;
    end else if (sym_vld) begin
      if (jk) begin
        prev_jk <= sym;
      end
      if (!unstuff_en || !jk || stuff_pos || !bit_dat) begin
        ones_cnt <= '0;
      end else begin
        ones_cnt <= ones_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/diff_line_rx.sv
// Differential line receiver: SYNC hunt, NRZI/unstuff, word assembly, EOP; outputs registered 1 cycle after bit_en.
// No backpressure: data_valid/eop/err are single-cycle pulses the consumer must take when offered.
module diff_line_rx
  import diff_line_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_p,
  input  logic              rx_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [1:0]        line_state,
  output logic              frame_active,
  output logic              eop,
  output logic [2:0]        err
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SYNC_W = $clog2(SYNC_LEN);

  rx_state_t         state, state_nxt;
  line_sym_t         sym, last_sym;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [SYNC_W-1:0] sync_cnt, sync_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              eop_se0, eop_se0_nxt;
  logic              word_done, eop_nxt, frame_active_nxt;
  rx_err_t           err_nxt, err_q;
  logic              bit_dat, bit_vld, stuff_err;

  always_comb begin
    sym = decode_sym(rx_p, rx_n);
  end

  diff_rx_nrzi_unstuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi (
    .clk        (clk),
    .rst        (rst),
    .sym_vld    (bit_en),
    .sym        (sym),
    .unstuff_en (state == ST_DATA),
    .bit_dat    (bit_dat),
    .bit_vld    (bit_vld),
    .stuff_err  (stuff_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SE1 overrides everything, including a stuff violation on the same sample.
  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      if (sym == LS_SE1) begin
        state_nxt = ST_ABORT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sym == LS_K && last_sym == LS_J) state_nxt = ST_SYNC;
          end
          ST_SYNC: begin
            if (!bit_vld) begin
              state_nxt = ST_IDLE;
            end else if (sync_cnt == SYNC_W'(SYNC_LEN - 1)) begin
              state_nxt = bit_dat ? ST_DATA : ST_IDLE;
            end else if (bit_dat) begin
              state_nxt = ST_IDLE;
            end
          end
          ST_DATA: begin
            if (sym == LS_SE0)  state_nxt = ST_EOP;
            else if (stuff_err) state_nxt = ST_ABORT;
          end
          ST_EOP: begin
            if (!eop_se0) state_nxt = (sym == LS_SE0) ? ST_EOP  : ST_ABORT;
            else          state_nxt = (sym == LS_J)   ? ST_IDLE : ST_ABORT;
          end
          ST_ABORT: begin
            if (sym == LS_J) state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sync_cnt_nxt     = sync_cnt;
    bit_cnt_nxt      = bit_cnt;
    shreg_nxt        = shreg;
    eop_se0_nxt      = eop_se0;
    word_done        = 1'b0;
    eop_nxt          = 1'b0;
    err_nxt          = '0;
    frame_active_nxt = (state_nxt == ST_DATA) || (state_nxt == ST_EOP);
    if (bit_en) begin
      err_nxt.se1   = (sym == LS_SE1);
      err_nxt.stuff = stuff_err;
      case (state)
        ST_IDLE: begin
          sync_cnt_nxt = SYNC_W'(1);
        end
        ST_SYNC: begin
          sync_cnt_nxt = sync_cnt + 1'b1;
          bit_cnt_nxt  = '0;
          eop_se0_nxt  = 1'b0;
        end
        ST_DATA: begin
          if (bit_vld) begin
            shreg_nxt = {bit_dat, shreg[DATA_W-1:1]};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt_nxt = '0;
              word_done   = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (!eop_se0 && sym == LS_SE0) begin
            eop_se0_nxt = 1'b1;
          end else if (eop_se0 && sym == LS_J) begin
            eop_nxt         = 1'b1;
            err_nxt.partial = (bit_cnt != '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      last_sym     <= LS_J;
      frame_active <= 1'b0;
      eop          <= 1'b0;
      err_q        <= '0;
      bit_cnt      <= '0;
      sync_cnt     <= '0;
      shreg        <= '0;
      eop_se0      <= 1'b0;
    end else begin
      data_valid   <= word_done;
      eop          <= eop_nxt;
      err_q        <= err_nxt;
      frame_active <= frame_active_nxt;
      bit_cnt      <= bit_cnt_nxt;
      sync_cnt     <= sync_cnt_nxt;
      shreg        <= shreg_nxt;
      eop_se0      <= eop_se0_nxt;
      if (bit_en)    last_sym <= sym;
      if (word_done) data_out <= shreg_nxt;
    end
  end

  assign line_state = last_sym;
  assign err        = err_q;

endmodule

// File: doc/diff_line_rx.md
DIFF_LINE_RX -- requirements
Module: diff_line_rx

Interface
REQ-001 Parameter DATA_W, default 8, meaning bits per received word.
REQ-002 Parameter STUFF_LEN, default 6, meaning consecutive decoded 1s after which a stuffed 0 is removed.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bit_en  input  1  one-cycle strobe; rx_p/rx_n sampled only on cycles with bit_en=1.
REQ-006 rx_p  input  1  positive leg of differential line, synchronous to clk.
REQ-007 rx_n  input  1  negative leg of differential line, synchronous to clk.
REQ-008 data_out  output  DATA_W  last completed word, LSB received first.
REQ-009 data_valid  output  1  one-cycle pulse, data_out valid.
REQ-010 line_state  output  2  registered line symbol: 0=SE0, 1=J, 2=K, 3=SE1.
REQ-011 frame_active  output  1  high from SYNC detection to end of frame.
REQ-012 eop  output  1  one-cycle pulse on valid end of packet.
REQ-013 err  output  3  one-cycle error pulses: [0]=stuff, [1]=SE1, [2]=partial word at EOP.

Function
REQ-014 Symbols SHALL decode as J=(p1,n0), K=(p0,n1), SE0=(0,0), SE1=(1,1); line_state SHALL update on every bit_en.
REQ-015 NRZI: a J/K symbol equal to the previous J/K symbol SHALL decode as 1; a different one SHALL decode as 0.
REQ-016 FSM states SHALL be IDLE, SYNC, DATA, EOP, ABORT.
REQ-017 IDLE: a K following J SHALL enter SYNC with sync count 1; any other symbol SHALL remain in IDLE.
REQ-018 SYNC: SHALL require six further decoded 0s then one decoded 1 (KJKJKJKK); the 1 SHALL enter DATA and set frame_active; any mismatch SHALL return to IDLE silently.
REQ-019 DATA: decoded bits SHALL shift into the word register LSB first; after STUFF_LEN consecutive 1s the next bit SHALL be discarded if 0.
REQ-020 A 1 in the stuffed-bit position SHALL pulse err[0] and enter ABORT.
REQ-021 On the DATA_W-th kept bit, data_out and data_valid SHALL register in the cycle after that bit_en cycle; the bit counter SHALL wrap to 0.
REQ-022 SE0 in DATA SHALL enter EOP without shifting; a second SE0 then J SHALL pulse eop, clear frame_active and return to IDLE.
REQ-023 At EOP, a nonzero bit counter SHALL additionally pulse err[2] in the same cycle as eop; the partial word SHALL be dropped.
REQ-024 In EOP, any symbol other than the required SE0,J sequence SHALL enter ABORT.
REQ-025 SE1 in any state SHALL pulse err[1] and enter ABORT; SE1 takes priority over stuff error in the same sample.
REQ-026 ABORT SHALL clear frame_active and return to IDLE on the first J sample.
REQ-027 Cycles without bit_en SHALL hold all state; pulse outputs SHALL be 0.

Reset
REQ-028 rst SHALL force IDLE, data_out=0, data_valid=0, line_state=1 (J), frame_active=0, eop=0, err=0, and clear the ones, bit and sync counters.
REQ-029 Assertion mid-frame SHALL discard the partial word with no eop or err pulse.

Structure
REQ-030 A shared package diff_line_rx_pkg SHALL hold the line-symbol enum, the FSM state enum and the SYNC length constant (8).
REQ-031 NRZI decode plus unstuffing SHALL live in sub-module diff_rx_nrzi_unstuff, outputting bit, bit_vld and stuff_err.

Verification
REQ-032 Idle J, SYNC, byte 0xA5 NRZI-encoded, SE0,SE0,J -> data_out=0xA5 one data_valid pulse, then eop, err=0.
REQ-033 SYNC, byte 0xFF with stuffed 0 after six 1s -> data_out=0xFF, exactly 8 kept bits, err=0.
REQ-034 SYNC, seven decoded 1s in DATA -> err[0] pulse, frame_active=0, no data_valid.
REQ-035 SYNC, 3 data bits, SE0,SE0,J -> eop and err[2] in the same cycle, no data_valid.
REQ-036 SE1 injected mid-byte -> err[1], ABORT; following valid frame 0x3C received correctly.
REQ-037 rst asserted mid-byte with bit_en gaps -> all outputs at reset values immediately, next frame received correctly.
